// File: rtl/imm_ctrl_pkg.sv
// Shared opcode, extender-select and buffer-state definitions for the ID-stage
// immediate controller.
package imm_ctrl_pkg;

  localparam logic [3:0] OP_ANDI = 4'b0100;
  localparam logic [3:0] OP_ADDI = 4'b0101;
  localparam logic [3:0] OP_LW   = 4'b0110;
  localparam logic [3:0] OP_SW   = 4'b0111;
  localparam logic [3:0] OP_BEQ  = 4'b1000;
  localparam logic [3:0] OP_BNE  = 4'b1001;
  localparam logic [3:0] OP_JMP  = 4'b1010;
  localparam logic [3:0] OP_CALL = 4'b1011;
  localparam logic [3:0] OP_SV   = 4'b1100;

  localparam logic IMM_SEL_I = 1'b0;
  localparam logic IMM_SEL_S = 1'b1;
  localparam logic EXT_ZERO  = 1'b0;
  localparam logic EXT_SIGN  = 1'b1;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } buf_state_t;

  typedef struct packed {
    logic imm_used;
    logic imm_sel;
    logic ext_op;
    logic illegal;
  } imm_ctl_t;

endpackage

// File: rtl/imm_opcode_decoder.sv
// Combinational opcode decode into extender controls and the illegal flag.
module imm_opcode_decoder
  import imm_ctrl_pkg::*;
(
  input  logic [3:0] opcode,
  output logic       imm_used,
  output logic       imm_sel,
  output logic       ext_op,
  output logic       illegal
);

  always_comb begin
    imm_used = 1'b0;
    imm_sel  = IMM_SEL_I;
    ext_op   = EXT_ZERO;
    illegal  = 1'b0;
    case (opcode)
      OP_ANDI: imm_used = 1'b1;
      OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_BNE: begin
        imm_used = 1'b1;
        ext_op   = EXT_SIGN;
      end
      OP_JMP, OP_CALL: begin
        imm_used = 1'b1;
        imm_sel  = IMM_SEL_S;
      end
      OP_SV: begin
        imm_used = 1'b1;
        imm_sel  = IMM_SEL_S;
        ext_op   = EXT_SIGN;
      end
      4'b1101, 4'b1110, 4'b1111: illegal = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/imm_decode_ctrl.sv
// ID-stage controller: decodes at accept, holds up to two decoded entries in a
// skid buffer and presents the head to EX and the immediate extender.
module imm_decode_ctrl
  import imm_ctrl_pkg::*;
#(
  parameter int PC_W  = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_instr,
  input  logic [PC_W-1:0]  in_pc,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_instr,
  output logic [PC_W-1:0]  out_pc,
  output logic             imm_sel,
  output logic             ext_op,
  output logic [4:0]       i_imm,
  output logic [8:0]       s_imm,
  output logic             imm_used,
  output logic             illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  buf_state_t      state, state_nxt;
  imm_ctl_t        dec_p0;
  imm_ctl_t        head_ctl_p1, skid_ctl_p1;
  logic [15:0]     head_instr_p1, skid_instr_p1;
  logic [PC_W-1:0] head_pc_p1, skid_pc_p1;
  logic            acc, pop;
  logic            ld_head_in, ld_head_skid, ld_skid;

  imm_opcode_decoder u_dec (
    .opcode   (in_instr[15:12]),
    .imm_used (dec_p0.imm_used),
    .imm_sel  (dec_p0.imm_sel),
    .ext_op   (dec_p0.ext_op),
    .illegal  (dec_p0.illegal)
  );

  assign acc = in_valid & in_ready & ~flush;
  assign pop = out_valid & out_ready;

  always_comb begin
    state_nxt    = state;
    ld_head_in   = 1'b0;
    ld_head_skid = 1'b0;
    ld_skid      = 1'b0;
    if (flush) begin
      state_nxt = ST_EMPTY;
    end else begin
      case (state)
        ST_EMPTY: if (acc) begin
          state_nxt  = ST_ONE;
          ld_head_in = 1'b1;
        end
        ST_ONE: begin
          if (acc && !pop) begin
            state_nxt = ST_TWO;
            ld_skid   = 1'b1;
          end else if (acc && pop) begin
            ld_head_in = 1'b1;
          end else if (pop) begin
            state_nxt = ST_EMPTY;
          end
        end
        ST_TWO: if (pop) begin
          state_nxt    = ST_ONE;
          ld_head_skid = 1'b1;
        end
        default: state_nxt = ST_EMPTY;
      endcase
    end
  end

  // Stage p1: buffer state, handshake outputs and the illegal counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_EMPTY;
      in_ready    <= 1'b0;
      out_valid   <= 1'b0;
      illegal_cnt <= '0;
    end else begin
      state     <= state_nxt;
      in_ready  <= (state_nxt != ST_TWO);
      out_valid <= (state_nxt != ST_EMPTY);
      if (acc && dec_p0.illegal && (illegal_cnt != {CNT_W{1'b1}}))
        illegal_cnt <= illegal_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Head entry is reset so EX sees zeroed fields while the core is held in reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_instr_p1 <= '0;
      head_pc_p1    <= '0;
      head_ctl_p1   <= '0;
    end else if (ld_head_in) begin
      head_instr_p1 <= in_instr;
      head_pc_p1    <= in_pc;
      head_ctl_p1   <= dec_p0;
    end else if (ld_head_skid) begin
      head_instr_p1 <= skid_instr_p1;
      head_pc_p1    <= skid_pc_p1;
      head_ctl_p1   <= skid_ctl_p1;
    end
  end

  always_ff @(posedge clk) begin
    if (ld_skid) begin
      skid_instr_p1 <= in_instr;
      skid_pc_p1    <= in_pc;
      skid_ctl_p1   <= dec_p0;
    end
  end

  assign out_instr = head_instr_p1;
  assign out_pc    = head_pc_p1;
  assign imm_sel   = head_ctl_p1.imm_sel;
  assign ext_op    = head_ctl_p1.ext_op;
  assign imm_used  = head_ctl_p1.imm_used;
  assign illegal   = head_ctl_p1.illegal;
  assign i_imm     = head_instr_p1[4:0];
  assign s_imm     = head_instr_p1[8:0];

endmodule

// File: tb/tb_imm_decode_ctrl.sv
// Randomized and directed bench for imm_decode_ctrl against a queue-based model.
module tb_imm_decode_ctrl;

  localparam int PC_W  = 16;
  localparam int CNT_W = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [15:0]      in_instr = '0;
  logic [PC_W-1:0]  in_pc = '0;
  logic             flush = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [15:0]      out_instr;
  logic [PC_W-1:0]  out_pc;
  logic             imm_sel;
  logic             ext_op;
  logic [4:0]       i_imm;
  logic [8:0]       s_imm;
  logic             imm_used;
  logic             illegal;
  logic [CNT_W-1:0] illegal_cnt;

  always #5 clk = ~clk;

  imm_decode_ctrl #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .in_pc       (in_pc),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_instr   (out_instr),
    .out_pc      (out_pc),
    .imm_sel     (imm_sel),
    .ext_op      (ext_op),
    .i_imm       (i_imm),
    .s_imm       (s_imm),
    .imm_used    (imm_used),
    .illegal     (illegal),
    .illegal_cnt (illegal_cnt)
  );

  typedef struct {
    logic [15:0]     instr;
    logic [PC_W-1:0] pc;
  } ent_t;

  ent_t q[$];
  int   m_cnt;
  bit   m_rdy;
  int   n_chk;
  int   n_pass;

  // Returns {imm_used, imm_sel, ext_op, illegal} from the opcode's numeric range.
  function automatic logic [3:0] ref_ctl(input logic [3:0] op);
    int o;
    o = int'(op);
    if (o <= 3)  return 4'b0000;
    if (o == 4)  return 4'b1000;
    if (o <= 9)  return 4'b1010;
    if (o <= 11) return 4'b1100;
    if (o == 12) return 4'b1110;
    return 4'b0001;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic check_outputs();
    logic [3:0] ctl;
    chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
    chk("in_ready", 32'(in_ready), 32'(m_rdy));
    chk("illegal_cnt", 32'(illegal_cnt), 32'(m_cnt));
    if (q.size() > 0) begin
      ctl = ref_ctl(q[0].instr[15:12]);
      chk("out_instr", 32'(out_instr), 32'(q[0].instr));
      chk("out_pc", 32'(out_pc), 32'(q[0].pc));
      chk("imm_used", 32'(imm_used), 32'(ctl[3]));
      chk("imm_sel", 32'(imm_sel), 32'(ctl[2]));
      chk("ext_op", 32'(ext_op), 32'(ctl[1]));
      chk("illegal", 32'(illegal), 32'(ctl[0]));
      chk("i_imm", 32'(i_imm), 32'(q[0].instr & 16'h001F));
      chk("s_imm", 32'(s_imm), 32'(q[0].instr & 16'h01FF));
    end
  endtask

  task automatic reset_chk();
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_out_instr", 32'(out_instr), 0);
    chk("rst_out_pc", 32'(out_pc), 0);
    chk("rst_imm_sel", 32'(imm_sel), 0);
    chk("rst_ext_op", 32'(ext_op), 0);
    chk("rst_imm_used", 32'(imm_used), 0);
    chk("rst_illegal", 32'(illegal), 0);
    chk("rst_illegal_cnt", 32'(illegal_cnt), 0);
  endtask

  task automatic model_reset();
    q.delete();
    m_cnt = 0;
    m_rdy = 1'b0;
  endtask

  // Called at a falling edge: check, drive, advance the model, wait one cycle.
  task automatic step(input logic v, input logic [15:0] ins, input logic [PC_W-1:0] pc,
                      input logic ordy, input logic fl);
    bit   acc, pop;
    ent_t e;
    check_outputs();
    in_valid  = v;
    in_instr  = ins;
    in_pc     = pc;
    out_ready = ordy;
    flush     = fl;
    acc = v && m_rdy && !fl;
    pop = (q.size() > 0) && ordy;
    if (fl) begin
      q.delete();
    end else begin
      if (pop) void'(q.pop_front());
      if (acc) begin
        e.instr = ins;
        e.pc    = pc;
        q.push_back(e);
      end
    end
    if (acc && int'(ins[15:12]) >= 13 && m_cnt < CNT_MAX) m_cnt++;
    m_rdy = (q.size() < 2);
    @(negedge clk);
  endtask

  logic [15:0] sext;

  initial begin
    n_chk  = 0;
    n_pass = 0;
    model_reset();
    repeat (2) @(negedge clk);
    reset_chk();
    reset_n = 1'b1;

    step(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0);
    step(1'b1, 16'h501F, 16'h0100, 1'b1, 1'b0);
    sext = ext_op ? {{11{i_imm[4]}}, i_imm} : {11'b0, i_imm};
    chk("addi_extended", 32'(sext), 32'h0000FFFF);

    step(1'b1, 16'hA1F0, 16'h0102, 1'b1, 1'b0);
    step(1'b1, 16'hC100, 16'h0104, 1'b1, 1'b0);
    step(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0);
    step(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0);

    step(1'b1, 16'h5003, 16'h0200, 1'b0, 1'b0);
    step(1'b1, 16'h6004, 16'h0202, 1'b0, 1'b0);
    step(1'b1, 16'h7005, 16'h0204, 1'b0, 1'b0);
    step(1'b1, 16'h7006, 16'h0206, 1'b0, 1'b0);
    repeat (3) step(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0);

    step(1'b1, 16'h8001, 16'h0300, 1'b0, 1'b0);
    step(1'b1, 16'h9002, 16'h0302, 1'b0, 1'b0);
    step(1'b1, 16'h4003, 16'h0304, 1'b0, 1'b1);
    repeat (2) step(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0);

    for (int i = 0; i < 300; i++)
      step(1'b1, {4'hF, 12'($urandom)}, 16'(i), 1'b1, 1'b0);
    step(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0);
    chk("cnt_saturated", 32'(illegal_cnt), 32'h000000FF);

    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 3) != 0, 16'($urandom), 16'($urandom),
           $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0);

    step(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1);
    step(1'b1, 16'h6ABC, 16'h1234, 1'b0, 1'b0);
    check_outputs();
    #2 reset_n = 1'b0;
    #1 reset_chk();
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    step(1'b1, 16'h5055, 16'h2000, 1'b1, 1'b0);
    step(1'b1, 16'hB1AA, 16'h2002, 1'b1, 1'b0);
    repeat (3) step(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0);

    for (int i = 0; i < 500; i++)
      step($urandom_range(0, 1) != 0, 16'($urandom), 16'($urandom),
           $urandom_range(0, 1) != 0, $urandom_range(0, 29) == 0);
    check_outputs();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/imm_decode_ctrl.md
Name: imm_decode_ctrl

Overview:
- ID-stage controller that sequences the immediate extender in the 16-bit pipelined core.
- Accepts fetched instructions from IF/ID through a valid/ready handshake and decodes the opcode.
- Drives the extender's type select, sign/zero select and immediate fields for each instruction, then hands the instruction to EX.
- Contains a 2-entry skid buffer, flush handling and a saturating illegal-opcode counter.

Parameters:
- PC_W, 16, width of the pc sideband carried with each instruction.
- CNT_W, 8, width of the illegal-opcode counter; the counter saturates at all-ones.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous active-low reset.
- in_valid  in  1  IF presents an instruction.
- in_ready  out  1  controller can accept an instruction.
- in_instr  in  16  instruction word.
- in_pc  in  PC_W  pc of in_instr.
- flush  in  1  branch/jump redirect; discards all buffered instructions.
- out_valid  out  1  decoded instruction is available to EX.
- out_ready  in  1  EX accepts the decoded instruction.
- out_instr  out  16  head instruction.
- out_pc  out  PC_W  pc of the head instruction.
- imm_sel  out  1  extender type select: 0 = I-type, 1 = S-type.
- ext_op  out  1  extender mode: 1 = sign-extend, 0 = zero-extend.
- i_imm  out  5  head instruction bits [4:0].
- s_imm  out  9  head instruction bits [8:0].
- imm_used  out  1  head instruction consumes the extended immediate.
- illegal  out  1  head opcode is undefined.
- illegal_cnt  out  CNT_W  count of illegal instructions accepted; saturating.

Behaviour:
- Reset (async assert, sync release): buffer empty; in_ready=0 during reset and 1 from the first clk edge after release; out_valid=0; out_instr=0; out_pc=0; imm_sel=0; ext_op=0; imm_used=0; illegal=0; illegal_cnt=0.
- Decode uses opcode in_instr[15:12] and is registered alongside the instruction. Total latency: in-accept to out_valid is 1 cycle.
- Opcode decode (imm_used/imm_sel/ext_op):
  - 0000-0011 R-type: 0/0/0.
  - 0100 ANDI: 1/0/0.
  - 0101 ADDI, 0110 LW, 0111 SW, 1000 BEQ, 1001 BNE: 1/0/1.
  - 1010 JMP, 1011 CALL: 1/1/0.
  - 1100 SV: 1/1/1.
  - 1101-1111: illegal=1, imm_used=0, imm_sel=0, ext_op=0.
- i_imm, s_imm, out_instr and out_pc reflect the head entry. Decode controls are registered per entry, never recomputed combinationally from in_instr.
- Buffer FSM, states EMPTY, ONE, TWO:
  - in_ready=1 in EMPTY and ONE; in_ready=0 in TWO. in_ready is registered and never combinational from out_ready.
  - out_valid=1 in ONE and TWO.
  - EMPTY: accept -> ONE.
  - ONE: accept with no pop -> TWO; pop with no accept -> EMPTY; accept and pop together -> stay ONE, new entry becomes head.
  - TWO: pop -> ONE, skid entry becomes head. in_valid is ignored.
- A pop (out_valid & out_ready) holds the outputs stable until that edge; head outputs are unchanged while out_ready=0.
- flush: all entries are invalidated next edge -> EMPTY, out_valid=0. An instruction presented in the same cycle as flush is dropped, and a pop in that cycle still counts as delivered. flush has priority over accept.
- illegal_cnt increments by 1 on accept of an illegal opcode, including one that is later flushed. It holds at 2^CNT_W-1. A flush in the same cycle as the accept suppresses the increment.
- Async reset mid-transfer clears all state immediately; no partial entry survives.

Decomposition:
- Shared package imm_ctrl_pkg holds:
  - 4-bit opcode localparams: OP_ANDI=4'b0100 … OP_SV=4'b1100.
  - IMM_SEL_I/IMM_SEL_S, EXT_ZERO/EXT_SIGN constants.
  - State encoding for EMPTY/ONE/TWO.
- One sub-module, imm_opcode_decoder: pure combinational opcode -> {imm_used, imm_sel, ext_op, illegal}, instantiated once at the input side. The buffer/FSM stays in the top.

Test Plan:
- Reset, then ADDI 16'h501F with out_ready=1 -> next cycle out_valid=1, imm_sel=0, ext_op=1, i_imm=5'h1F (extender yields 16'hFFFF).
- JMP 16'hA1F0 then SV 16'hC100, with out_ready=1 -> JMP head gives imm_sel=1, ext_op=0, s_imm=9'h1F0; SV head gives imm_sel=1, ext_op=1, s_imm=9'h100.
- Back-pressure: out_ready=0, three instructions offered back-to-back -> first two accepted, in_ready=0 in TWO. Release out_ready -> heads emerge in order with no loss or duplication.
- Flush while in TWO with in_valid=1 -> next cycle out_valid=0, state EMPTY; the presented instruction is never output.
- 300 accepts of opcode 4'b1111 with CNT_W=8 -> illegal=1 each time, illegal_cnt saturates at 8'hFF.
- Assert reset_n low while in ONE with out_ready=0 -> outputs clear immediately, without waiting for a clock edge. After release, the first valid is accepted on the first edge.
